uart_rx_mmio: RTL
=================

// Module: uart_rx_mmio
// PURPOSE
//  UART 8N1 receiver with a small RX FIFO. Memory-mapped responder on the peripheral
//  load/store bus (rd/wr/addr/wdata/rdata) that the CPU drives from its MEM stage.
//  Sits beside the LED/switch/digit-tube peripheral and raises irqout when data waits.
// PARAMETERS
//  CLKS_PER_BIT  10417         clk cycles per UART bit (100 MHz / 9600 baud); >= 4
//  FIFO_DEPTH    4             RX FIFO entries; power of two, 2..16
//  BASE_ADDR     32'h4000_001C byte address of RXD; CON is at BASE_ADDR+4
// PORTS
//  clk      in   1   system clock; single clock domain
//  reset    in   1   asynchronous, active-high reset
//  rd       in   1   bus read strobe (MEM stage)
//  wr       in   1   bus write strobe (MEM stage)
//  addr     in   32  bus byte address
//  wdata    in   32  bus write data
//  rdata    out  32  bus read data; combinational, 0 when not selected
//  UART_RX  in   1   serial input, asynchronous to clk, idle high
//  irqout   out  1   interrupt request, level
// BEHAVIOUR
//  Reset: rdata=0, irqout=0; FIFO empty; flags and irq_en = 0; FSM=IDLE; synchronizer = 1.
//  Input: UART_RX passes through a 2-flop synchronizer (rx_s). The FSM uses only rx_s.
//  Bit counter: width $clog2(CLKS_PER_BIT). The bit index counts 0..7.
//  FSM:
//   IDLE : when rx_s==0, go to START and clear the counter.
//   START: at count CLKS_PER_BIT/2-1, sample rx_s.
//          0 -> go to DATA, clear the counter and bit index.
//          1 -> glitch; go to IDLE and drop the frame.
//   DATA : at every count CLKS_PER_BIT-1, shift rx_s into the shift register, LSB first.
//          After bit 7, go to STOP.
//   STOP : at count CLKS_PER_BIT-1 (mid stop bit), sample rx_s, then go to IDLE.
//          1 and FIFO not full -> push the byte.
//          1 and FIFO full     -> drop the byte; set ovf (sticky).
//          0                   -> drop the byte; set ferr (sticky).
//  Registers:
//   RXD (BASE_ADDR) read: rdata = {24'b0, FIFO head}, or 0 if the FIFO is empty.
//       A read pops the head at the clock edge (rd && addr==RXD && !empty).
//       Writes to RXD are ignored.
//   CON (BASE_ADDR+4) read: rdata = {25'b0, count[2:0], irq_en, ferr, ovf, !empty}.
//       For FIFO_DEPTH > 7, count saturates at 7.
//       Write: wdata[3] sets irq_en. wdata[1]=1 clears ovf; wdata[2]=1 clears ferr (W1C).
//  Address decode: full 32-bit compare. Other addresses give rdata=0 and no side effect.
//  irqout = irq_en & !empty, driven from registered state.
//   Rises in the cycle after the push edge.
//   Falls in the cycle after the pop that empties the FIFO.
//  Latency: a byte is readable from the cycle after the mid-stop-bit sample.
//  Simultaneous events:
//   Push and pop in the same cycle when full: pop first, then push. Count stays at
//    FIFO_DEPTH; ovf is not set.
//   Push and pop in the same cycle when empty: push only. The read returns 0.
//   Flag set and W1C clear in the same cycle: set wins.
//   rd and wr in the same cycle: both take effect.
//  Pointer wrap: pointers are $clog2(FIFO_DEPTH)+1 bits.
//   full  = MSBs differ and the low bits are equal.
//   empty = pointers are equal.
//  Reset mid-frame: everything returns to reset values at once and the partial byte is
//   lost. The next falling edge of rx_s after reset starts a new frame.
// STRUCTURE
//  Shared header uart_defs.vh:
//   FSM state encodings (IDLE/START/DATA/STOP, 2 bits).
//   RXD/CON offsets and CON bit positions (VALID=0, OVF=1, FERR=2, IRQEN=3, CNT=6:4).
//  Sub-module rx_fifo: synchronous FIFO. Ports: push/din/pop/dout/full/empty/count;
//   same clk and reset. Everything else stays in uart_rx_mmio.
// TESTING (CLKS_PER_BIT=16, FIFO_DEPTH=4)
//  1. Send 0xA5 as an 8N1 frame, then read CON -> 0x11.
//     Read RXD -> 0xA5. Then read CON -> 0x00.
//  2. Glitch: UART_RX low for 4 cycles, then high -> no push; CON stays 0x00;
//     FSM back in IDLE within 10 cycles.
//  3. Frame with stop bit 0 -> CON = 0x04, FIFO empty.
//     Write CON with 0x04 -> CON reads 0x00.
//  4. Five bytes 0x01..0x05 with no reads -> CON = 0x43 (count 4, ovf, valid).
//     Reads return 0x01, 0x02, 0x03, 0x04, then 0x00.
//  5. FIFO full; pop issued on the exact push cycle of a 5th byte 0x55 -> count stays 4,
//     ovf=0. Drain order: 2nd, 3rd and 4th byte, then 0x55.
//  6. Write CON 0x08; receive 0x3C -> irqout rises one cycle after the push and falls one
//     cycle after the RXD read. Then assert reset mid-DATA -> all outputs 0.
//     A following frame 0x3C is received intact.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// Shared types and register map for the UART receiver peripheral.
// FSM encodings, register offsets and CON bit positions.
package uart_rx_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic [31:0] RXD_OFF = 32'h0;
  localparam logic [31:0] CON_OFF = 32'h4;

  localparam int CON_VALID = 0;
  localparam int CON_OVF   = 1;
  localparam int CON_FERR  = 2;
  localparam int CON_IRQEN = 3;
  localparam int CON_CNT   = 4;

  function automatic logic [2:0] sat_cnt(
    input logic [4:0] c
  );
    return (c > 5'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/uart_rx_mmio_fifo.sv
// Synchronous byte FIFO for received UART data.
// Pop is applied before push, so a full FIFO accepts a push alongside a pop.
module rx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_pop;
  logic        do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign dout  = mem[rp[AW-1:0]];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver with RX FIFO, memory-mapped on the peripheral bus.
// Raises a level interrupt while enabled and data is waiting.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_001C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        UART_RX,
  output logic        irqout
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_m;
  logic          rx_s;
  rx_state_e     state;
  rx_state_e     state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          cnt_clr;
  logic          idx_clr;
  logic          shift_en;
  logic          stop_smp;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    dout;
  logic [AW:0]   count;

  logic          sel_rxd;
  logic          sel_con;
  logic          con_wr;
  logic          irq_en;
  logic          ovf;
  logic          ferr;
  logic          ovf_set;
  logic          ferr_set;
  logic [31:0]   con_word;
  logic          unused_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= UART_RX;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: if (cnt == HALF) state_n = rx_s ? IDLE : DATA;
      DATA:  if (cnt == LAST && idx == 3'd7) state_n = STOP;
      STOP:  if (cnt == LAST) state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    stop_smp = 1'b0;
    unique case (state)
      IDLE:  cnt_clr = 1'b1;
      START: begin
        cnt_clr = (cnt == HALF);
        idx_clr = (cnt == HALF);
      end
      DATA: begin
        cnt_clr  = (cnt == LAST);
        shift_en = (cnt == LAST);
      end
      STOP: begin
        cnt_clr  = (cnt == LAST);
        stop_smp = (cnt == LAST);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (idx_clr)
        idx <= '0;
      else if (shift_en)
        idx <= idx + 3'd1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  assign sel_rxd  = (addr == BASE_ADDR + RXD_OFF);
  assign sel_con  = (addr == BASE_ADDR + CON_OFF);
  assign pop      = rd & sel_rxd & ~empty;
  assign push     = stop_smp & rx_s;
  assign con_wr   = wr & sel_con;
  // a push into a full FIFO only loses data if no pop frees a slot
  assign ovf_set  = stop_smp & rx_s & full & ~pop;
  assign ferr_set = stop_smp & ~rx_s;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (con_wr) irq_en <= wdata[CON_IRQEN];
      ovf  <= ovf_set  | (ovf  & ~(con_wr & wdata[CON_OVF]));
      ferr <= ferr_set | (ferr & ~(con_wr & wdata[CON_FERR]));
    end
  end

  always_comb begin
    con_word = '0;
    con_word[CON_VALID]     = ~empty;
    con_word[CON_OVF]       = ovf;
    con_word[CON_FERR]      = ferr;
    con_word[CON_IRQEN]     = irq_en;
    con_word[CON_CNT +: 3]  = sat_cnt(5'(count));
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd && sel_rxd: rdata = empty ? '0 : {24'b0, dout};
      rd && sel_con: rdata = con_word;
      default:       rdata = '0;
    endcase
  end

  assign irqout = irq_en & ~empty;

  assign unused_wdata = ^{wdata[31:4], wdata[0]};

endmodule
